// File: rtl/serdes_link_pkg.sv
// Shared definitions for the serial link transmit trainer and the receive-side bitslip aligner.
// Both ends take their pattern and idle words from here.
package serdes_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } link_state_e;

  localparam logic [7:0] DEF_TRAINING_PATTERN = 8'b11110000;
  localparam logic [7:0] DEF_IDLE_WORD        = 8'h00;

endpackage

// File: rtl/oserdes_tx_trainer.sv
// Parallel word source for an 8:1 DDR OSERDESE2: sends the training pattern until the far end holds
// lock, then forwards payload through valid/ready, filling gaps with the idle word.
module oserdes_tx_trainer
  import serdes_link_pkg::*;
#(
  parameter logic [7:0]  TRAINING_PATTERN = DEF_TRAINING_PATTERN,
  parameter logic [7:0]  IDLE_WORD        = DEF_IDLE_WORD,
  parameter logic [15:0] MIN_TRAIN        = 16'd64,
  parameter logic [7:0]  LOCK_HOLD        = 8'd8,
  parameter logic [15:0] TRAIN_TIMEOUT    = 16'd4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       retrain,
  input  logic       rx_locked,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] tx_word,
  output logic       training,
  output logic       link_up,
  output logic       train_fail
);

  link_state_e state, state_nxt;
  logic [15:0] train_cnt, train_cnt_nxt;
  logic [7:0]  hold_cnt, hold_cnt_nxt;
  logic [7:0]  tx_nxt;
  logic        lock_qual;
  logic        timeout_hit;

  // train_cnt holds the pattern words already issued, so the word issued this cycle is number
  // train_cnt+1; both the minimum-training and the timeout thresholds count that word.
  always_comb begin
    lock_qual   = (train_cnt >= MIN_TRAIN - 16'd1) && rx_locked &&
                  (hold_cnt == LOCK_HOLD - 8'd1);
    timeout_hit = (train_cnt == TRAIN_TIMEOUT - 16'd1);
    data_ready  = (state == ST_DATA) && EN && rx_locked && !retrain;
  end

  always_comb begin
    state_nxt     = ST_IDLE;
    train_cnt_nxt = 16'd0;
    hold_cnt_nxt  = 8'd0;
    tx_nxt        = IDLE_WORD;
    train_fail    = 1'b0;
    if (EN) begin
      case (state)
        ST_IDLE: state_nxt = ST_TRAIN;
        ST_TRAIN: begin
          state_nxt = ST_TRAIN;
          tx_nxt    = TRAINING_PATTERN;
          if (!retrain) begin
            if (lock_qual) begin
              state_nxt = ST_DATA;
            end else begin
              // hold_cnt parks at LOCK_HOLD-1 while lock persists but training is still too short
              if (rx_locked)
                hold_cnt_nxt = (hold_cnt == LOCK_HOLD - 8'd1) ? hold_cnt : hold_cnt + 8'd1;
              if (timeout_hit) begin
                train_fail    = 1'b1;
                train_cnt_nxt = 16'd0;
              end else begin
                train_cnt_nxt = (train_cnt == 16'hFFFF) ? train_cnt : train_cnt + 16'd1;
              end
            end
          end
        end
        ST_DATA: begin
          state_nxt = ST_DATA;
          if (data_ready && data_valid)
            tx_nxt = data_in;
          if (!rx_locked || retrain)
            state_nxt = ST_TRAIN;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_word   <= IDLE_WORD;
      train_cnt <= 16'd0;
      hold_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      tx_word   <= tx_nxt;
      train_cnt <= train_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  assign training = (state == ST_TRAIN);
  assign link_up  = (state == ST_DATA);

endmodule

// File: tb/tb_oserdes_tx_trainer.sv
// Bench for oserdes_tx_trainer: directed link bring-up scenarios, a vector table in DATA,
// and randomized traffic checked cycle by cycle against a behavioural link model.
module tb_oserdes_tx_trainer;

  localparam int MIN_TRAIN = 64;
  localparam int LOCK_HOLD = 8;
  localparam int TIMEOUT   = 4096;
  localparam logic [7:0] PAT  = 8'hF0;
  localparam logic [7:0] IDLE = 8'h00;

  logic       clk;
  logic       rst_n, EN, retrain, rx_locked, data_valid;
  logic [7:0] data_in;
  logic       data_ready, training, link_up, train_fail;
  logic [7:0] tx_word;

  oserdes_tx_trainer dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .retrain(retrain), .rx_locked(rx_locked),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .tx_word(tx_word), .training(training), .link_up(link_up), .train_fail(train_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: link mode (0 idle, 1 training, 2 data), pattern words issued so far,
  // length of the current unbroken lock run, and the word due on tx_word.
  bit         m_ok = 0;
  int         m_mode, m_words, m_run;
  logic [7:0] m_tx;

  logic [7:0] obs_tx;
  logic       obs_rdy, obs_trn, obs_lnk, obs_fail;

  typedef struct {
    logic       en, rt, lk, v;
    logic [7:0] d;
    logic [7:0] tx;
    logic       rdy, trn, lnk;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rt, input logic lk,
                      input logic v, input logic [7:0] d);
    logic exp_rdy, exp_fail, qual;
    @(negedge clk);
    rst_n = r; EN = e; retrain = rt; rx_locked = lk; data_valid = v; data_in = d;
    #1;
    obs_tx = tx_word; obs_rdy = data_ready; obs_trn = training;
    obs_lnk = link_up; obs_fail = train_fail;
    qual     = (m_words + 1 >= MIN_TRAIN) && lk && (m_run + 1 >= LOCK_HOLD);
    exp_rdy  = (m_mode == 2) && e && lk && !rt;
    exp_fail = (m_mode == 1) && e && !rt && !qual && (m_words + 1 == TIMEOUT);
    if (m_ok) begin
      chk("tx_word", tx_word, m_tx);
      chk("data_ready", data_ready, exp_rdy);
      chk("training", training, m_mode == 1);
      chk("link_up", link_up, m_mode == 2);
      chk("train_fail", train_fail, exp_fail);
    end
    @(posedge clk);
    if (!r) begin
      m_ok = 1; m_mode = 0; m_tx = IDLE; m_words = 0; m_run = 0;
    end else if (!e) begin
      m_mode = 0; m_tx = IDLE; m_words = 0; m_run = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_tx = IDLE; m_words = 0; m_run = 0;
    end else if (m_mode == 1) begin
      m_tx = PAT;
      if (rt) begin
        m_words = 0; m_run = 0;
      end else if (qual) begin
        m_mode = 2; m_words = 0; m_run = 0;
      end else begin
        m_run = lk ? m_run + 1 : 0;
        m_words = (m_words + 1 == TIMEOUT) ? 0 : m_words + 1;
      end
    end else begin
      m_tx = (exp_rdy && v) ? d : IDLE;
      if (!lk || rt) begin
        m_mode = 1; m_words = 0; m_run = 0;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic to_data(input string name);
    int n = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    while (!obs_lnk && n < 300) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      n++;
    end
    chk(name, obs_lnk, 1);
  endtask

  initial begin
    int first_link, f0_cnt, drops, bad_tx;
    int fail_at[$];
    logic r, e, rt, lk, v;

    rst_n = 1'b0; EN = 1'b0; retrain = 1'b0; rx_locked = 1'b0;
    data_valid = 1'b0; data_in = 8'h00;

    tbl[0] = '{1, 0, 1, 1, 8'h11, 8'h3C, 1, 0, 1};
    tbl[1] = '{1, 0, 1, 0, 8'h00, 8'h11, 1, 0, 1};
    tbl[2] = '{1, 0, 1, 1, 8'h22, 8'h00, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 1, 8'h33, 8'h22, 0, 0, 1};
    tbl[4] = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0};
    tbl[5] = '{1, 0, 1, 0, 8'h00, 8'hF0, 0, 1, 0};

    // Reset then nominal bring-up with lock present from the start
    do_reset();
    first_link = -1; f0_cnt = 0;
    for (int k = 0; k <= 66; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, (k == 65 || k == 66), (k == 65) ? 8'hA5 : 8'h3C);
      if (k == 0) begin
        chk("rst_tx", obs_tx, 8'h00);
        chk("rst_ready", obs_rdy, 0);
        chk("rst_training", obs_trn, 0);
        chk("rst_link", obs_lnk, 0);
      end
      if (obs_tx == PAT) f0_cnt++;
      if (obs_lnk && first_link < 0) first_link = k;
    end
    chk("t2_pattern_words", f0_cnt, 64);
    chk("t2_link_cycle", first_link, 65);
    chk("t2_word_a5", obs_tx, 8'hA5);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].en, tbl[i].rt, tbl[i].lk, tbl[i].v, tbl[i].d);
      chk("tbl_tx", obs_tx, tbl[i].tx);
      chk("tbl_ready", obs_rdy, tbl[i].rdy);
      chk("tbl_training", obs_trn, tbl[i].trn);
      chk("tbl_link", obs_lnk, tbl[i].lnk);
    end

    // Late lock with a short glitch: only the final unbroken run qualifies
    do_reset();
    first_link = -1;
    for (int k = 0; k <= 120; k++) begin
      step(1'b1, 1'b1, 1'b0, (k >= 100 && k < 103) || k >= 110, 1'b0, 8'h00);
      if (obs_lnk && first_link < 0) first_link = k;
    end
    chk("t3_link_cycle", first_link, 118);

    // Loss of lock in DATA with a word offered
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
    chk("t5_ready_on_drop", obs_rdy, 0);
    bad_tx = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      if (obs_tx == 8'h5A) bad_tx++;
      if (k == 0) begin
        chk("t5_training", obs_trn, 1);
        chk("t5_tx_after_drop", obs_tx, 8'h00);
      end
    end
    chk("t5_5a_leaked", bad_tx, 0);

    // Disable mid-DATA, retrain pulse while idle, then full retraining
    to_data("t6_reach_data");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("t6_link_off", obs_lnk, 0);
    chk("t6_idle_tx", obs_tx, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_retrain_ignored", obs_trn, 0);
    f0_cnt = 0;
    first_link = 0;
    for (int k = 0; k < 200 && !obs_lnk; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      if (obs_tx == PAT) f0_cnt++;
      first_link = k;
    end
    chk("t6_relinked", obs_lnk, 1);
    chk("t6_pattern_words", f0_cnt, 64);

    // Reset while a payload word is being accepted
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("mid_rst_tx", obs_tx, 8'h00);
    chk("mid_rst_link", obs_lnk, 0);

    // Training timeout with lock never present
    do_reset();
    drops = 0; bad_tx = 0;
    for (int k = 0; k <= 8200; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      if (obs_fail) fail_at.push_back(k);
      if (k >= 1 && !obs_trn) drops++;
      if (k >= 2 && obs_tx != PAT) bad_tx++;
    end
    chk("t4_fail_count", fail_at.size(), 2);
    if (fail_at.size() >= 2) begin
      chk("t4_fail_first", fail_at[0], 4096);
      chk("t4_fail_second", fail_at[1], 8192);
    end
    chk("t4_training_drops", drops, 0);
    chk("t4_tx_not_pattern", bad_tx, 0);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      r  = ($urandom_range(0, 999) != 0);
      e  = ($urandom_range(0, 399) != 0);
      rt = ($urandom_range(0, 249) == 0);
      lk = ($urandom_range(0, 79) != 0);
      v  = $urandom_range(0, 1);
      step(r, e, rt, lk, v, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
